acl_mmio_bridge: RTL and testbench

ACL_MMIO_BRIDGE -- requirements
Module: acl_mmio_bridge

---
 rtl/acl_mmio_bridge.sv | 193 +++++++++++++++++++
 tb/tb_acl_mmio_bridge.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acl_mmio_bridge.sv
// Memory-mapped bridge between a soft CPU data port, its RAM and an accelerometer
// sample FIFO with a programmable sample period and an LED register.
module acl_mmio_bridge #(
  parameter int          DEPTH          = 8,
  parameter logic [15:0] DEFAULT_PERIOD = 16'd40000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_wren,
  input  logic [11:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        ram_wren,
  output logic [11:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic [14:0] acl_data,
  output logic [14:0] led
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [14:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [15:0]   r_period;
  logic [15:0]   r_samp_cnt;
  logic [14:0]   r_led;
  logic [31:0]   r_mmio_rdata;
  logic          r_sel_mmio;
  logic          r_rd_en;

  logic          w_in_win;
  logic          w_wr_status;
  logic          w_wr_period;
  logic          w_wr_led;
  logic          w_wr_pop;
  logic          w_empty;
  logic          w_full;
  logic          w_sample;
  logic          w_pop;
  logic          w_push;
  logic          w_ovf_set;
  logic [CW-1:0] w_count_nxt;
  logic [15:0]   w_period_new;
  logic [14:0]   w_head;
  logic [4:0]    w_count5;
  logic [31:0]   w_mmio_rdata;

  assign ram_addr  = cpu_addr;
  assign ram_wdata = cpu_wdata;
  assign ram_wren  = cpu_wren & ~w_in_win;
  assign led       = r_led;
  assign cpu_rdata = r_rd_en ? (r_sel_mmio ? r_mmio_rdata : ram_rdata) : 32'h0000_0000;

  // Window decode and register write strobes
  always_comb begin
    w_in_win    = (cpu_addr[11:4] == 8'hF0);
    w_wr_status = 1'b0;
    w_wr_period = 1'b0;
    w_wr_led    = 1'b0;
    w_wr_pop    = 1'b0;
    if (cpu_wren && w_in_win) begin
      case (cpu_addr[3:0])
        4'h0:    w_wr_status = 1'b1;
        4'h2:    w_wr_period = 1'b1;
        4'h3:    w_wr_led    = 1'b1;
        4'h4:    w_wr_pop    = 1'b1;
        default: w_wr_status = 1'b0;
      endcase
    end else begin
      w_wr_status = 1'b0;
    end
  end

  // FIFO push/pop arbitration; a pop frees the slot a same-edge push needs
  always_comb begin
    w_empty   = (r_count == {CW{1'b0}});
    w_full    = (r_count == FULL_CNT);
    w_sample  = (r_samp_cnt >= (r_period - 16'd1));
    w_pop     = w_wr_pop && !w_empty;
    w_push    = w_sample && (!w_full || w_pop);
    w_ovf_set = w_sample && w_full && !w_pop;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
    if (cpu_wdata[15:0] < 16'd2) begin
      w_period_new = 16'd2;
    end else begin
      w_period_new = cpu_wdata[15:0];
    end
  end

  // Read data for the window registers
  always_comb begin
    w_count5 = 5'(r_count);
    if (w_empty) begin
      w_head = 15'd0;
    end else begin
      w_head = r_mem[r_rd_ptr];
    end
    case (cpu_addr[3:0])
      4'h0:    w_mmio_rdata = {22'd0, w_count5, 3'd0, r_overflow, w_empty};
      4'h1:    w_mmio_rdata = {17'd0, w_head};
      4'h2:    w_mmio_rdata = {16'd0, r_period};
      4'h3:    w_mmio_rdata = {17'd0, r_led};
      default: w_mmio_rdata = 32'd0;
    endcase
  end

  // Sample period and free-running sample counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_period   <= DEFAULT_PERIOD;
      r_samp_cnt <= 16'd0;
    end else if (w_wr_period) begin
      r_period   <= w_period_new;
      r_samp_cnt <= 16'd0;
    end else if (w_sample) begin
      r_samp_cnt <= 16'd0;
    end else begin
      r_samp_cnt <= r_samp_cnt + 16'd1;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= {AW{1'b0}};
      r_wr_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // FIFO storage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 15'd0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= acl_data;
    end
  end

  // Sticky overflow; a same-edge set beats the clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (w_wr_status && cpu_wdata[1]) begin
      r_overflow <= 1'b0;
    end
  end

  // LED register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_led <= 15'd0;
    end else if (w_wr_led) begin
      r_led <= cpu_wdata[14:0];
    end
  end

  // Read path registered at the address edge so it lines up with the RAM's latency
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mmio_rdata <= 32'd0;
      r_sel_mmio   <= 1'b0;
      r_rd_en      <= 1'b0;
    end else begin
      r_mmio_rdata <= w_in_win ? w_mmio_rdata : 32'd0;
      r_sel_mmio   <= w_in_win;
      r_rd_en      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_acl_mmio_bridge.sv
// Self-checking bench for acl_mmio_bridge: directed scenarios plus a randomized
// bus stream compared against a queue-based model of the register map and FIFO.
module tb_acl_mmio_bridge;

  localparam int DEPTH = 8;

  logic        clock;
  logic        reset;
  logic        cpu_wren;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        ram_wren;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [14:0] acl_data;
  logic [14:0] led;

  int n_checks = 0;
  int n_fail   = 0;

  acl_mmio_bridge #(.DEPTH(DEPTH), .DEFAULT_PERIOD(16'd40000)) dut (
    .clock(clock), .reset(reset),
    .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .ram_wren(ram_wren), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .acl_data(acl_data), .led(led)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bench RAM: registered read, written only when the bridge asserts ram_wren
  logic [31:0] ram_mem [0:4095];
  always @(posedge clock) begin
    if (ram_wren) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  // Reference model
  logic [14:0] m_q[$];
  logic        m_ovf;
  int          m_period;
  int          m_since;
  logic [14:0] m_led;
  logic [31:0] m_ram [0:4095];
  logic [31:0] m_rd_exp;

  task automatic model_reset();
    m_q.delete();
    m_ovf    = 1'b0;
    m_period = 40000;
    m_since  = 0;
    m_led    = 15'd0;
  endtask

  task automatic model_edge();
    logic [11:0] a;
    logic [31:0] rd;
    bit          in_win;
    a      = cpu_addr;
    in_win = (a >= 12'hF00) && (a <= 12'hF0F);
    rd     = 32'd0;
    if (in_win) begin
      if (a == 12'hF00) rd = {22'd0, 5'(m_q.size()), 3'd0, m_ovf, (m_q.size() == 0)};
      if (a == 12'hF01) rd = (m_q.size() == 0) ? 32'd0 : {17'd0, m_q[0]};
      if (a == 12'hF02) rd = 32'(m_period);
      if (a == 12'hF03) rd = {17'd0, m_led};
    end else begin
      rd = m_ram[a];
    end
    m_rd_exp = rd;
    m_since++;
    if (cpu_wren && a == 12'hF04 && m_q.size() > 0) void'(m_q.pop_front());
    if (cpu_wren && a == 12'hF00 && cpu_wdata[1]) m_ovf = 1'b0;
    if ((m_since % m_period) == 0) begin
      if (m_q.size() < DEPTH) m_q.push_back(acl_data);
      else m_ovf = 1'b1;
    end
    if (cpu_wren && a == 12'hF02) begin
      m_period = (cpu_wdata[15:0] < 16'd2) ? 2 : int'(cpu_wdata[15:0]);
      m_since  = 0;
    end
    if (cpu_wren && a == 12'hF03) m_led = cpu_wdata[14:0];
    if (cpu_wren && !in_win) m_ram[a] = cpu_wdata;
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    cpu_wren = 1'b1; cpu_addr = a; cpu_wdata = d;
    step();
    cpu_wren = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
    cpu_wren = 1'b0; cpu_addr = a; cpu_wdata = $urandom;
    step();
    d = cpu_rdata;
  endtask

  task automatic idle(input int n);
    cpu_wren = 1'b0; cpu_addr = 12'h100;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0; cpu_wren = 1'b0; cpu_addr = 12'h000; cpu_wdata = 32'd0; acl_data = 15'd0;
    model_reset();
    #12;
    n_checks++; if (cpu_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want %h", cpu_rdata, 32'd0); end
    n_checks++; if (led !== 15'd0) begin n_fail++; $display("FAIL reset_led: got %h want %h", led, 15'd0); end
    n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL reset_ram_wren: got %b want 0", ram_wren); end
    reset = 1'b1;
    bus_read(12'hF00, d);
    n_checks++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL reset_status: got %h want %h", d, 32'h1); end
    bus_read(12'hF02, d);
    n_checks++; if (d !== 32'd40000) begin n_fail++; $display("FAIL reset_period: got %h want %h", d, 32'd40000); end
  endtask

  task automatic test_ram_passthrough();
    logic [31:0] d;
    cpu_wren = 1'b1; cpu_addr = 12'h010; cpu_wdata = 32'hDEADBEEF;
    #1;
    n_checks++; if (ram_wren !== 1'b1) begin n_fail++; $display("FAIL ram_store_wren: got %b want 1", ram_wren); end
    n_checks++; if (ram_addr !== 12'h010 || ram_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_store_bus: got %h/%h want 010/deadbeef", ram_addr, ram_wdata); end
    step();
    cpu_wren = 1'b0;
    bus_read(12'h010, d);
    n_checks++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_load: got %h want deadbeef", d); end
    cpu_wren = 1'b1; cpu_addr = 12'hF03; cpu_wdata = 32'h0000_7FFF;
    #1;
    n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL led_store_wren: got %b want 0", ram_wren); end
    step();
    cpu_wren = 1'b0;
    n_checks++; if (led !== 15'h7FFF) begin n_fail++; $display("FAIL led_value: got %h want 7fff", led); end
    bus_read(12'hF03, d);
    n_checks++; if (d !== 32'h0000_7FFF) begin n_fail++; $display("FAIL led_readback: got %h want 7fff", d); end
  endtask

  task automatic test_pop_empty();
    logic [31:0] d;
    bus_write(12'hF04, 32'd1);
    bus_read(12'hF00, d);
    n_checks++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL pop_empty_status: got %h want 1", d); end
    bus_read(12'hF01, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL empty_data: got %h want 0", d); end
    bus_write(12'hF02, 32'd1);
    bus_read(12'hF02, d);
    n_checks++; if (d !== 32'd2) begin n_fail++; $display("FAIL period_clamp: got %h want 2", d); end
    bus_write(12'hF02, 32'd1000);
    bus_write(12'hF04, 32'd0);
    bus_read(12'hF00, d);
    n_checks++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL drain_status: got %h want 1", d); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] d;
    acl_data = 15'h0ABC;
    bus_write(12'hF02, 32'd4);
    idle(12);
    bus_read(12'hF00, d);
    n_checks++; if (d !== 32'h0000_0060) begin n_fail++; $display("FAIL fill3_status: got %h want 60", d); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (led !== 15'd0) begin n_fail++; $display("FAIL midreset_led: got %h want 0", led); end
    n_checks++; if (cpu_rdata !== 32'd0) begin n_fail++; $display("FAIL midreset_rdata: got %h want 0", cpu_rdata); end
    n_checks++; if (dut.r_count !== 4'd0 || dut.r_period !== 16'd40000) begin n_fail++; $display("FAIL midreset_state: got count %h period %h want 0/40000", dut.r_count, dut.r_period); end
    @(posedge clock); #1;
    model_reset();
    reset = 1'b1;
    bus_read(12'hF00, d);
    n_checks++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL postreset_status: got %h want 1", d); end
    bus_read(12'hF02, d);
    n_checks++; if (d !== 32'd40000) begin n_fail++; $display("FAIL postreset_period: got %h want 40000", d); end
  endtask

  task automatic test_sampling();
    logic [31:0] d;
    acl_data = 15'h1234;
    bus_write(12'hF02, 32'd4);
    idle(4);
    bus_read(12'hF00, d);
    n_checks++; if (d !== 32'h0000_0020) begin n_fail++; $display("FAIL first_sample_status: got %h want 20", d); end
    bus_read(12'hF01, d);
    n_checks++; if (d !== 32'h0000_1234) begin n_fail++; $display("FAIL first_sample_data: got %h want 1234", d); end
    for (int i = 0; i < 40; i++) begin
      acl_data = 15'($urandom);
      idle(1);
    end
    bus_read(12'hF00, d);
    n_checks++; if (d !== 32'h0000_0102) begin n_fail++; $display("FAIL overflow_status: got %h want 102", d); end
    bus_write(12'hF02, 32'd1000);
    bus_write(12'hF00, 32'h0000_0002);
    bus_read(12'hF00, d);
    n_checks++; if (d !== 32'h0000_0100) begin n_fail++; $display("FAIL w1c_status: got %h want 100", d); end
  endtask

  task automatic test_full_pop();
    logic [31:0] d;
    logic [14:0] h1;
    h1 = m_q[1];
    acl_data = 15'($urandom);
    bus_write(12'hF02, 32'd4);
    idle(3);
    bus_write(12'hF04, 32'd0);
    bus_read(12'hF00, d);
    n_checks++; if (d !== 32'h0000_0100) begin n_fail++; $display("FAIL full_pop_status: got %h want 100", d); end
    bus_read(12'hF01, d);
    n_checks++; if (d !== {17'd0, h1}) begin n_fail++; $display("FAIL full_pop_head: got %h want %h", d, {17'd0, h1}); end
    bus_write(12'hF02, 32'd1000);
  endtask

  task automatic test_random();
    int op;
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 5);
      acl_data  = 15'($urandom);
      cpu_wdata = $urandom;
      cpu_wren  = 1'b0;
      case (op)
        0: cpu_addr = 12'hF00 + 12'($urandom_range(0, 15));
        1: begin
          cpu_wren = 1'b1;
          cpu_addr = 12'hF00 + 12'($urandom_range(0, 5));
          if (cpu_addr == 12'hF02) cpu_wdata = 32'($urandom_range(0, 9));
        end
        2: begin cpu_wren = 1'b1; cpu_addr = 12'($urandom_range(0, 63)); end
        3: cpu_addr = 12'($urandom_range(0, 63));
        4: cpu_addr = 12'($urandom_range(64, 127));
        default: begin cpu_wren = 1'b1; cpu_addr = 12'hF04; end
      endcase
      #1;
      n_checks++;
      if (ram_wren !== (cpu_wren && (cpu_addr < 12'hF00 || cpu_addr > 12'hF0F))) begin
        n_fail++; $display("FAIL rand_ram_wren: addr %h wren %b got %b", cpu_addr, cpu_wren, ram_wren);
      end
      step();
      n_checks++;
      if (cpu_rdata !== m_rd_exp) begin
        n_fail++; $display("FAIL rand_rdata: cycle %0d addr %h got %h want %h", i, cpu_addr, cpu_rdata, m_rd_exp);
      end
      n_checks++;
      if (led !== m_led) begin
        n_fail++; $display("FAIL rand_led: got %h want %h", led, m_led);
      end
    end
    cpu_wren = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram_mem[i] = 32'd0;
      m_ram[i]   = 32'd0;
    end
    test_reset();
    test_ram_passthrough();
    test_pop_empty();
    test_reset_midop();
    test_sampling();
    test_full_pop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
